// File: rtl/plab3_mem_line_mem_responder_pkg.sv
// Shared message layout, type codes and byte-lane helpers for the line memory responder.
package plab3_mem_line_mem_responder_pkg;

    localparam int ABW        = 32;
    localparam int CLW        = 128;
    localparam int OPAQUE_W   = 8;
    localparam int LEN_W      = 4;
    localparam int TYPE_W     = 3;
    localparam int REQ_NBITS  = TYPE_W + OPAQUE_W + ABW + LEN_W + CLW;
    localparam int RESP_NBITS = TYPE_W + OPAQUE_W + LEN_W + CLW;

    localparam logic [TYPE_W-1:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [TYPE_W-1:0] MEM_TYPE_WRITE = 3'd1;

    typedef struct packed {
        logic [TYPE_W-1:0]   msg_type;
        logic [OPAQUE_W-1:0] opaque;
        logic [ABW-1:0]      addr;
        logic [LEN_W-1:0]    len;
        logic [CLW-1:0]      data;
    } mem_req_t;

    typedef struct packed {
        logic [TYPE_W-1:0]   msg_type;
        logic [OPAQUE_W-1:0] opaque;
        logic [LEN_W-1:0]    len;
        logic [CLW-1:0]      data;
    } mem_resp_t;

    function automatic mem_req_t mem_req_unpack(input logic [REQ_NBITS-1:0] bits);
        return mem_req_t'(bits);
    endfunction

    function automatic logic [RESP_NBITS-1:0] mem_resp_pack(input mem_resp_t msg);
        return RESP_NBITS'(msg);
    endfunction

    // A zero length field encodes a full 16-byte line.
    function automatic logic [4:0] len_nbytes(input logic [LEN_W-1:0] len);
        return (len == 4'd0) ? 5'd16 : {1'b0, len};
    endfunction

    function automatic logic [15:0] first_bytes_mask(input logic [4:0] n);
        logic [15:0] m;
        m = 16'h0000;
        for (int b = 0; b < 16; b++) begin
            m[b] = (5'(b) < n);
        end
        return m;
    endfunction

    function automatic logic [CLW-1:0] expand_byte_mask(input logic [15:0] m);
        logic [CLW-1:0] e;
        e = '0;
        for (int b = 0; b < 16; b++) begin
            e[8*b +: 8] = {8{m[b]}};
        end
        return e;
    endfunction

    // Lanes shifted past byte 15 fall off, so a write never spills into the next line.
    function automatic logic [15:0] write_byte_mask(input logic [3:0] off, input logic [LEN_W-1:0] len);
        return first_bytes_mask(len_nbytes(len)) << off;
    endfunction

    function automatic logic [CLW-1:0] write_line_data(input logic [3:0] off, input logic [CLW-1:0] data);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [CLW-1:0] read_line_data(input logic [CLW-1:0] line, input logic [3:0] off,
                                                      input logic [LEN_W-1:0] len);
        return (line >> {off, 3'b000}) & expand_byte_mask(first_bytes_mask(len_nbytes(len)));
    endfunction

endpackage

// File: rtl/plab3_mem_line_mem_responder_if.sv
// memreq/memresp val/rdy channel pair; the cache is master, the memory is slave.
interface plab3_mem_line_mem_responder_if;
    import plab3_mem_line_mem_responder_pkg::*;

    logic [REQ_NBITS-1:0]  memreq_msg;
    logic                  memreq_val;
    logic                  memreq_rdy;
    logic [RESP_NBITS-1:0] memresp_msg;
    logic                  memresp_val;
    logic                  memresp_rdy;

    modport master (
        output memreq_msg, memreq_val, memresp_rdy,
        input  memreq_rdy, memresp_msg, memresp_val
    );

    modport slave (
        input  memreq_msg, memreq_val, memresp_rdy,
        output memreq_rdy, memresp_msg, memresp_val
    );
endinterface

// File: rtl/plab3_mem_line_mem_responder_array.sv
// Line-wide storage with per-byte write enables and a combinational read port.
module plab3_mem_LineMemArray #(
    parameter int p_nlines = 256,
    parameter int p_idx_w  = 8
) (
    input  logic               clk,
    input  logic [15:0]        wen,
    input  logic [p_idx_w-1:0] widx,
    input  logic [127:0]       wdata,
    input  logic [p_idx_w-1:0] ridx,
    output logic [127:0]       rdata
);

    logic [127:0] mem_r [p_nlines];

    // Byte-enabled line write; contents survive reset by design.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 16; b++) begin
            if (wen[b]) begin
                mem_r[widx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = mem_r[ridx];

endmodule

// File: rtl/plab3_mem_line_mem_responder.sv
// Memory end of the cache memreq/memresp port: one line request at a time, answered after p_latency wait cycles.
module plab3_mem_line_mem_responder
    import plab3_mem_line_mem_responder_pkg::*;
#(
    parameter int p_mem_nbytes = 4096,
    parameter int p_latency    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    plab3_mem_line_mem_responder_if.slave mem
);

    localparam int c_nlines = p_mem_nbytes / 16;
    localparam int c_idx_w  = (c_nlines > 1) ? $clog2(c_nlines) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]         state_r;
    logic [1:0]         state_next_s;
    logic [7:0]         cnt_r;
    logic [7:0]         cnt_next_s;
    logic               rdy_r;
    logic               val_r;
    mem_resp_t          resp_r;
    mem_resp_t          resp_next_s;

    mem_req_t           req_s;
    logic               accept_s;
    logic [3:0]         off_s;
    logic [c_idx_w-1:0] idx_s;
    logic [15:0]        wen_s;
    logic [127:0]       wdata_s;
    logic [127:0]       line_s;
    logic               unused_addr_s;

    assign req_s    = mem_req_unpack(mem.memreq_msg);
    assign accept_s = mem.memreq_val & rdy_r;
    assign off_s    = req_s.addr[3:0];
    // Upper address bits are ignored so the address space wraps at p_mem_nbytes.
    assign idx_s    = (c_nlines > 1) ? req_s.addr[c_idx_w+3:4] : '0;
    assign wdata_s  = write_line_data(off_s, req_s.data);
    assign wen_s    = (accept_s && (req_s.msg_type == MEM_TYPE_WRITE)) ? write_byte_mask(off_s, req_s.len)
                                                                        : 16'h0000;
    assign unused_addr_s = ^req_s.addr[ABW-1:c_idx_w+4];

    plab3_mem_LineMemArray #(
        .p_nlines (c_nlines),
        .p_idx_w  (c_idx_w)
    ) u_array (
        .clk   (clk),
        .wen   (wen_s),
        .widx  (idx_s),
        .wdata (wdata_s),
        .ridx  (idx_s),
        .rdata (line_s)
    );

    // Response payload formed from the array contents as they stand at the accept edge.
    always_comb begin
        resp_next_s          = '0;
        resp_next_s.msg_type = req_s.msg_type;
        resp_next_s.opaque   = req_s.opaque;
        resp_next_s.len      = req_s.len;
        if (req_s.msg_type == MEM_TYPE_READ) begin
            resp_next_s.data = read_line_data(line_s, off_s, req_s.len);
        end else begin
            resp_next_s.data = '0;
        end
    end

    // Next-state and latency counter logic.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (p_latency > 0) begin
                        state_next_s = WAIT;
                        cnt_next_s   = 8'(p_latency - 1);
                    end else begin
                        state_next_s = RESP;
                        cnt_next_s   = 8'd0;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 8'd0) begin
                    state_next_s = RESP;
                end else begin
                    cnt_next_s = cnt_r - 8'd1;
                end
            end
            RESP: begin
                if (mem.memresp_rdy) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = 8'd0;
            end
        endcase
    end

    // State, handshake flags and response register; rdy/val are decoded from the next state so they stay registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 8'd0;
            rdy_r   <= 1'b1;
            val_r   <= 1'b0;
            resp_r  <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            rdy_r   <= (state_next_s == IDLE);
            val_r   <= (state_next_s == RESP);
            if (accept_s) begin
                resp_r <= resp_next_s;
            end
        end
    end

    assign mem.memreq_rdy  = rdy_r;
    assign mem.memresp_val = val_r;
    assign mem.memresp_msg = mem_resp_pack(resp_r);

endmodule

// File: tb/tb_plab3_mem_line_mem_responder.sv
// Randomized self-checking bench: a p_latency=2 and a p_latency=0 responder checked against a byte-array model.
module tb_plab3_mem_line_mem_responder;

    localparam logic [2:0] T_READ  = 3'd0;
    localparam logic [2:0] T_WRITE = 3'd1;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [7:0] mdl [2][4096];

    always #5 clk = ~clk;

    plab3_mem_line_mem_responder_if bus ();
    plab3_mem_line_mem_responder_if bus0 ();

    plab3_mem_line_mem_responder #(.p_mem_nbytes(4096), .p_latency(2)) dut (
        .clk(clk), .reset(rst_n), .mem(bus.slave));
    plab3_mem_line_mem_responder #(.p_mem_nbytes(4096), .p_latency(0)) dut0 (
        .clk(clk), .reset(rst_n), .mem(bus0.slave));

    function automatic int exp_lat(input int u);
        return (u == 1) ? 0 : 2;
    endfunction

    function automatic int nbytes_of(input logic [3:0] len);
        return (len == 4'd0) ? 16 : int'(len);
    endfunction

    function automatic logic [127:0] model_read(input int u, input logic [31:0] a, input logic [3:0] len);
        logic [127:0] r;
        int la, base, off;
        r = '0;
        la = int'(a[11:0]);
        off = la % 16;
        base = la - off;
        for (int k = 0; k < 16; k++)
            if (k < nbytes_of(len) && off + k < 16) r[8*k +: 8] = mdl[u][base + off + k];
        return r;
    endfunction

    task automatic model_write(input int u, input logic [31:0] a, input logic [3:0] len, input logic [127:0] d);
        int la, base, off;
        la = int'(a[11:0]);
        off = la % 16;
        base = la - off;
        for (int k = 0; k < 16; k++)
            if (k < nbytes_of(len) && off + k < 16) mdl[u][base + off + k] = d[8*k +: 8];
    endtask

    function automatic logic [142:0] exp_resp(input int u, input logic [2:0] t, input logic [7:0] opq,
                                              input logic [31:0] a, input logic [3:0] len);
        logic [127:0] d;
        d = (t == T_READ) ? model_read(u, a, len) : 128'h0;
        return {t, opq, len, d};
    endfunction

    task automatic set_req(input int u, input logic [174:0] m, input logic v);
        if (u == 1) begin bus0.memreq_msg = m; bus0.memreq_val = v; end
        else begin bus.memreq_msg = m; bus.memreq_val = v; end
    endtask

    task automatic set_resp_rdy(input int u, input logic v);
        if (u == 1) bus0.memresp_rdy = v; else bus.memresp_rdy = v;
    endtask

    function automatic logic get_req_rdy(input int u);
        return (u == 1) ? bus0.memreq_rdy : bus.memreq_rdy;
    endfunction

    function automatic logic get_resp_val(input int u);
        return (u == 1) ? bus0.memresp_val : bus.memresp_val;
    endfunction

    function automatic logic [142:0] get_resp_msg(input int u);
        return (u == 1) ? bus0.memresp_msg : bus.memresp_msg;
    endfunction

    // One full transaction; lat = clock edges from the accept edge until val is seen (cycle N+1+p_latency).
    task automatic xact(input int u, input logic [2:0] t, input logic [7:0] opq, input logic [31:0] a,
                        input logic [3:0] len, input logic [127:0] d,
                        output logic [142:0] resp, output int lat, output logic rdy_after, output logic val_after);
        int guard;
        @(negedge clk);
        set_req(u, {t, opq, a, len, d}, 1'b1);
        guard = 0;
        while (!get_req_rdy(u) && guard < 100) begin @(negedge clk); guard++; end
        @(posedge clk);
        @(negedge clk);
        set_req(u, {t, opq, a, len, d}, 1'b0);
        rdy_after = get_req_rdy(u);
        lat = 0;
        while (!get_resp_val(u) && lat < 100) begin @(negedge clk); lat++; end
        resp = get_resp_msg(u);
        set_resp_rdy(u, 1'b1);
        @(negedge clk);
        set_resp_rdy(u, 1'b0);
        val_after = get_resp_val(u);
    endtask

    task automatic test_reset;
        for (int u = 0; u < 2; u++) begin
            checks++;
            if (get_req_rdy(u) !== 1'b1 || get_resp_val(u) !== 1'b0 || get_resp_msg(u) !== 143'h0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy=%b val=%b msg=%h, want rdy=1 val=0 msg=0",
                         u, get_req_rdy(u), get_resp_val(u), get_resp_msg(u));
            end
        end
    endtask

    task automatic test_full_line;
        logic [142:0] r; int lat; logic ra, va;
        logic [127:0] line = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        xact(0, T_WRITE, 8'h11, 32'h100, 4'd0, line, r, lat, ra, va);
        model_write(0, 32'h100, 4'd0, line);
        checks++;
        if (r !== {T_WRITE, 8'h11, 4'd0, 128'h0} || lat !== 2) begin
            errors++; $display("FAIL full_write: resp=%h lat=%0d, want data 0 lat=2", r, lat);
        end
        xact(0, T_READ, 8'h12, 32'h100, 4'd0, 128'h0, r, lat, ra, va);
        checks++;
        if (r !== {T_READ, 8'h12, 4'd0, line} || lat !== 2 || va !== 1'b0) begin
            errors++; $display("FAIL full_read: resp=%h lat=%0d val_after=%b, want line %h lat=2", r, lat, va, line);
        end
    endtask

    task automatic test_zero_latency;
        logic [142:0] r; int lat; logic ra, va;
        logic [127:0] line;
        line = {$urandom, $urandom, $urandom, $urandom};
        xact(1, T_WRITE, 8'h21, 32'h200, 4'd0, line, r, lat, ra, va);
        model_write(1, 32'h200, 4'd0, line);
        xact(1, T_READ, 8'h22, 32'h200, 4'd0, 128'h0, r, lat, ra, va);
        checks++;
        if (lat !== 0 || ra !== 1'b0) begin
            errors++; $display("FAIL zero_lat_timing: lat=%0d rdy=%b, want lat=0 rdy=0", lat, ra);
        end
        checks++;
        if (r !== {T_READ, 8'h22, 4'd0, line}) begin
            errors++; $display("FAIL zero_lat_data: got %h want %h", r, {T_READ, 8'h22, 4'd0, line});
        end
    endtask

    task automatic test_backpressure;
        logic [142:0] r, snap, want, want2; int lat, guard; logic ra, va, stable;
        logic [127:0] line, line2;
        line  = {$urandom, $urandom, $urandom, $urandom};
        line2 = {$urandom, $urandom, $urandom, $urandom};
        xact(0, T_WRITE, 8'h30, 32'h600, 4'd0, line, r, lat, ra, va);
        model_write(0, 32'h600, 4'd0, line);
        want = exp_resp(0, T_READ, 8'h3C, 32'h600, 4'd0);
        @(negedge clk);
        set_req(0, {T_READ, 8'h3C, 32'h600, 4'd0, 128'h0}, 1'b1);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 175'h0, 1'b0);
        guard = 0;
        while (!bus.memresp_val && guard < 100) begin @(negedge clk); guard++; end
        snap = bus.memresp_msg;
        checks++;
        if (snap !== want) begin errors++; $display("FAIL bp_data: got %h want %h", snap, want); end
        want2 = exp_resp(0, T_WRITE, 8'h3D, 32'h610, 4'd0);
        set_req(0, {T_WRITE, 8'h3D, 32'h610, 4'd0, line2}, 1'b1);
        stable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.memresp_msg !== snap || bus.memreq_rdy !== 1'b0 || bus.memresp_val !== 1'b1) stable = 1'b0;
        end
        checks++;
        if (!stable) begin errors++; $display("FAIL bp_hold: msg/val/rdy changed under backpressure, want stable"); end
        bus.memresp_rdy = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.memresp_rdy = 1'b0;
        checks++;
        if (bus.memreq_rdy !== 1'b1 || bus.memresp_val !== 1'b0) begin
            errors++; $display("FAIL bp_release: rdy=%b val=%b, want rdy=1 val=0", bus.memreq_rdy, bus.memresp_val);
        end
        @(posedge clk);
        model_write(0, 32'h610, 4'd0, line2);
        @(negedge clk);
        set_req(0, 175'h0, 1'b0);
        checks++;
        if (bus.memreq_rdy !== 1'b0) begin errors++; $display("FAIL bp_queued_accept: rdy=%b want 0", bus.memreq_rdy); end
        lat = 0;
        while (!bus.memresp_val && lat < 100) begin @(negedge clk); lat++; end
        checks++;
        if (bus.memresp_msg !== want2 || lat !== 2) begin
            errors++; $display("FAIL bp_queued_resp: got %h lat=%0d want %h lat=2", bus.memresp_msg, lat, want2);
        end
        bus.memresp_rdy = 1'b1;
        @(negedge clk);
        bus.memresp_rdy = 1'b0;
    endtask

    task automatic test_partial_write;
        logic [142:0] r; int lat; logic ra, va;
        logic [127:0] want;
        xact(0, T_WRITE, 8'h40, 32'h100, 4'd0, 128'h0, r, lat, ra, va);
        model_write(0, 32'h100, 4'd0, 128'h0);
        xact(0, T_WRITE, 8'h41, 32'h10C, 4'd4, 128'hDEADBEEF, r, lat, ra, va);
        model_write(0, 32'h10C, 4'd4, 128'hDEADBEEF);
        checks++;
        if (r !== {T_WRITE, 8'h41, 4'd4, 128'h0}) begin
            errors++; $display("FAIL partial_write_resp: got %h", r);
        end
        xact(0, T_READ, 8'h42, 32'h100, 4'd0, 128'h0, r, lat, ra, va);
        want = 128'hDEADBEEF_00000000_00000000_00000000;
        checks++;
        if (r[127:0] !== want || r[127:0] !== model_read(0, 32'h100, 4'd0)) begin
            errors++; $display("FAIL partial_read1: got %h want %h", r[127:0], want);
        end
        xact(0, T_WRITE, 8'h43, 32'h10E, 4'd4, 128'h11223344, r, lat, ra, va);
        model_write(0, 32'h10E, 4'd4, 128'h11223344);
        xact(0, T_READ, 8'h44, 32'h100, 4'd0, 128'h0, r, lat, ra, va);
        want = 128'h3344BEEF_00000000_00000000_00000000;
        checks++;
        if (r[127:0] !== want || r[127:0] !== model_read(0, 32'h100, 4'd0)) begin
            errors++; $display("FAIL partial_read2: got %h want %h", r[127:0], want);
        end
    endtask

    task automatic test_wrap;
        logic [142:0] r; int lat; logic ra, va;
        logic [127:0] line;
        line = {$urandom, $urandom, $urandom, $urandom};
        xact(0, T_WRITE, 8'hA5, 32'h1000, 4'd0, line, r, lat, ra, va);
        model_write(0, 32'h1000, 4'd0, line);
        xact(0, T_READ, 8'hA5, 32'h0000, 4'd0, 128'h0, r, lat, ra, va);
        checks++;
        if (r !== {T_READ, 8'hA5, 4'd0, line}) begin
            errors++; $display("FAIL wrap: got %h want %h", r, {T_READ, 8'hA5, 4'd0, line});
        end
    endtask

    task automatic test_random;
        logic [142:0] r, want; int lat, u, k, sel; logic ra, va;
        logic [2:0] t; logic [7:0] opq; logic [31:0] a; logic [3:0] len; logic [127:0] d;
        for (int uu = 0; uu < 2; uu++)
            for (int kk = 0; kk < 8; kk++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                a = 32'h700 + 32'(kk * 16);
                xact(uu, T_WRITE, 8'h00, a, 4'd0, d, r, lat, ra, va);
                model_write(uu, a, 4'd0, d);
            end
        for (int i = 0; i < 40; i++) begin
            u = int'($urandom % 2);
            k = int'($urandom % 8);
            sel = int'($urandom % 10);
            t = (sel < 4) ? T_READ : (sel < 8) ? T_WRITE : 3'(2 + $urandom % 6);
            opq = 8'($urandom);
            len = 4'($urandom);
            d = {$urandom, $urandom, $urandom, $urandom};
            a = ($urandom & 32'hFFFF_F000) | (32'h700 + 32'(k * 16) + 32'($urandom % 16));
            want = exp_resp(u, t, opq, a, len);
            xact(u, t, opq, a, len, d, r, lat, ra, va);
            if (t == T_WRITE) model_write(u, a, len, d);
            checks++;
            if (r !== want || lat !== exp_lat(u)) begin
                errors++;
                $display("FAIL random[%0d] dut%0d t=%0d a=%h len=%0d: got %h lat=%0d want %h lat=%0d",
                         i, u, t, a, len, r, lat, want, exp_lat(u));
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [142:0] r; int lat; logic ra, va, quiet;
        logic [127:0] line;
        line = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        set_req(0, {T_WRITE, 8'h55, 32'h500, 4'd0, line}, 1'b1);
        @(posedge clk);
        model_write(0, 32'h500, 4'd0, line);
        @(negedge clk);
        set_req(0, 175'h0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.memresp_val !== 1'b0 || bus.memreq_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_async: val=%b rdy=%b, want val=0 rdy=1", bus.memresp_val, bus.memreq_rdy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.memresp_val !== 1'b0 || bus.memreq_rdy !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin errors++; $display("FAIL reset_dropped: response or busy seen after reset, want idle"); end
        xact(0, T_READ, 8'h56, 32'h500, 4'd0, 128'h0, r, lat, ra, va);
        checks++;
        if (r !== {T_READ, 8'h56, 4'd0, line}) begin
            errors++; $display("FAIL reset_data_kept: got %h want %h", r, {T_READ, 8'h56, 4'd0, line});
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_req(0, 175'h0, 1'b0);
        set_req(1, 175'h0, 1'b0);
        set_resp_rdy(0, 1'b0);
        set_resp_rdy(1, 1'b0);
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_full_line();
        test_zero_latency();
        test_backpressure();
        test_partial_write();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
